// File: rtl/frontend_egress.sv
// Packet egress: reads a packet from the shared packet BRAM starting at address 0 and
// streams it out as AXI-Stream beats with byte enables and tlast, then pulses finish.
module frontend_egress #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic [15:0]         length_be,
    output logic                finish,
    output logic                bram_enb,
    output logic [ADDR_W-1:0]   bram_addrb,
    input  logic [DATA_W-1:0]   bram_doutb,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready
);

    localparam int BYTES     = DATA_W / 8;
    localparam int OFF_W     = $clog2(BYTES);
    localparam int MAX_BEATS = 1 << ADDR_W;
    localparam int MAX_BYTES = MAX_BEATS * BYTES;
    localparam int CNT_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   beats_q;
    logic [BYTES-1:0]   last_keep_q;
    logic [CNT_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   sent;
    logic [RD_LAT-1:0]  rd_vld_p;
    logic [DATA_W-1:0]  buf_data [2];
    logic               buf_wr_ptr;
    logic               buf_rd_ptr;
    logic [1:0]         buf_count;
    logic               issue;
    logic               push;
    logic               pop;
    logic               is_last;
    int                 inflight;

    // Beat count rounded up to whole beats, clamped to the BRAM depth.
    function automatic logic [CNT_W-1:0] sat_beats(input logic [15:0] len);
        logic [16:0] ceil_beats;
        ceil_beats = ({1'b0, len} + 17'(BYTES - 1)) >> OFF_W;
        if (ceil_beats > 17'(MAX_BEATS))
            return CNT_W'(MAX_BEATS);
        return ceil_beats[CNT_W-1:0];
    endfunction

    // Byte enables of the final beat; an oversize packet is truncated to full beats.
    function automatic logic [BYTES-1:0] tail_keep(input logic [15:0] len);
        logic [OFF_W-1:0] rem;
        rem = len[OFF_W-1:0];
        if (len > 16'(MAX_BYTES) || rem == '0)
            return '1;
        return {BYTES{1'b1}} >> (BYTES - int'(rem));
    endfunction

    assign m_axis_tvalid = (buf_count != 2'd0);
    assign is_last       = (sent == beats_q - 1'b1);
    assign m_axis_tlast  = m_axis_tvalid && is_last;
    assign m_axis_tkeep  = !m_axis_tvalid ? '0 : (is_last ? last_keep_q : '1);
    assign m_axis_tdata  = buf_data[buf_rd_ptr];
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push          = rd_vld_p[RD_LAT-1];
    assign bram_enb      = issue;

    always_comb begin
        inflight = $countones(rd_vld_p);
    end

    // Read 0 is issued straight from IDLE so the first beat is buffered two cycles after start;
    // a same-cycle pop frees a slot, which keeps the stream gap-free under constant tready.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        finish     = 1'b0;
        bram_addrb = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    issue     = (length_be != 16'd0);
                    state_nxt = (length_be == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue = (rd_addr < beats_q) &&
                        (int'(buf_count) + inflight - int'(pop) < 2);
                if (issue)
                    bram_addrb = rd_addr[ADDR_W-1:0];
                if (pop && is_last)
                    state_nxt = DONE;
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: control state, packet parameters and read address/beat counters
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            beats_q     <= '0;
            last_keep_q <= '0;
            rd_addr     <= '0;
            sent        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                beats_q     <= sat_beats(length_be);
                last_keep_q <= tail_keep(length_be);
            end
            if (state == IDLE)
                rd_addr <= issue ? CNT_W'(1) : '0;
            else if (issue)
                rd_addr <= rd_addr + 1'b1;
            if (state == IDLE)
                sent <= '0;
            else if (pop)
                sent <= sent + 1'b1;
        end
    end

    // p1: read-valid tracking matched to the BRAM latency
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p[0] <= issue;
            for (int i = 1; i < RD_LAT; i++)
                rd_vld_p[i] <= rd_vld_p[i-1];
        end
    end

    // p2: two-entry output buffer; head entry is the beat presented on the stream
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_wr_ptr  <= 1'b0;
            buf_rd_ptr  <= 1'b0;
            buf_count   <= 2'd0;
        end else begin
            if (push) begin
                buf_data[buf_wr_ptr] <= bram_doutb;
                buf_wr_ptr           <= ~buf_wr_ptr;
            end
            if (pop)
                buf_rd_ptr <= ~buf_rd_ptr;
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

endmodule
